// File: rtl/dec_scoreboard.sv
// Decode-stage result-availability scoreboard: per-register countdowns that stall
// dependent instructions until their result can be forwarded.
// Optional stall-cycle counter enabled by defining DEC_SCOREBOARD_STATS_EN.
module dec_scoreboard #(
  parameter int NREGS = 64,
  parameter int CNTW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Flush,
  input  logic            IssueValid,
  input  logic            IssueWrites,
  input  logic [5:0]      IssueRd,
  input  logic [CNTW-1:0] IssueLatency,
  input  logic [5:0]      Rs1,
  input  logic [5:0]      Rs2,
  input  logic            UsesRs1,
  input  logic            UsesRs2,
  output logic            Stall,
  output logic            Busy
`ifdef DEC_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]     StallCycles
`endif
);

  logic [CNTW-1:0] cnt_q [NREGS];
  logic [CNTW-1:0] cnt_d [NREGS];
  logic            busy_q;
  logic            busy_d;

  logic            rs1_pending;
  logic            rs2_pending;
  logic            issue_load;
  logic [CNTW-1:0] issue_dec;
  logic [CNTW-1:0] issue_val;

  // Register 0 is hardwired and never tracked as pending.
  always_comb begin
    rs1_pending = (Rs1 != '0) && (cnt_q[Rs1] != '0);
    rs2_pending = (Rs2 != '0) && (cnt_q[Rs2] != '0);
    Stall       = (UsesRs1 && rs1_pending) || (UsesRs2 && rs2_pending);
    issue_load  = IssueValid && IssueWrites && (IssueRd != '0) && !Stall;
    issue_dec   = (cnt_q[IssueRd] != '0) ? cnt_q[IssueRd] - 1'b1 : '0;
    // Keeping the larger remaining latency stops a younger fast write from
    // unmasking an older slow write to the same register.
    issue_val   = (IssueLatency > issue_dec) ? IssueLatency : issue_dec;
  end

  // NOTE: every variable gets a value on every path through always_comb so no latch is inferred.
  always_comb begin
    busy_d = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
    end
    if (issue_load) begin
      cnt_d[IssueRd] = issue_val;
    end
    if (Flush) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_d[r] = '0;
      end
    end
    for (int r = 0; r < NREGS; r++) begin
      busy_d = busy_d | (cnt_d[r] != '0);
    end
  end

  // NOTE: the countdown array is a bank of flops, not RAM, and must be reset so
  // that no stale pending entry survives a mid-operation reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q <= busy_d;
    end
  end

  assign Busy = busy_q;

`ifdef DEC_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  // Flushed cycles are not counted as stalls; the counter sticks at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (Stall && !Flush && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign StallCycles = stall_cycles_q;
`endif

endmodule

// File: doc/dec_scoreboard.md
Name: dec_scoreboard

Overview:
- Decode-stage result-availability tracker; the producer-side counterpart of decode forwarding.
- Records, at issue, when each destination register's result becomes forwardable.
- Counts those latencies down every cycle and stalls decode when a source operand is not yet available through the MEM/WB forward paths. Covers load-use and multi-cycle (mult/div) results.
- Sits beside decode forwarding; its Stall output gates the IF/ID pipeline registers and injects a bubble into EX.

Parameters:
- NREGS, 64, number of architectural registers tracked (6-bit index, int + FP file).
- CNTW, 4, width of each per-register countdown; the maximum latency is 2**CNTW-1.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- Flush  input  1  branch/exception squash; clears all pending state.
- IssueValid  input  1  decode instruction leaves ID this cycle (already qualified by Stall upstream).
- IssueWrites  input  1  issuing instruction writes a register.
- IssueRd  input  [0:5]  destination register of the issuing instruction.
- IssueLatency  input  [0:CNTW-1]  cycles until the result is forwardable (0 = forwardable next cycle, 1 = load, >1 = mult/div).
- Rs1  input  [0:5]  decode source register 1.
- Rs2  input  [0:5]  decode source register 2.
- UsesRs1  input  1  instruction reads Rs1.
- UsesRs2  input  1  instruction reads Rs2.
- Stall  output  1  hold IF/ID and insert a bubble.
- Busy  output  1  at least one register has a nonzero countdown.

Behaviour:
- State: Cnt[r], one CNTW-bit countdown per register, plus a registered Busy flag.
- Reset: while rst_n=0 at a rising edge, every Cnt is set to 0 and Busy to 0. Stall therefore reads 0 from the first cycle after reset. Reset mid-operation discards all pending entries.
- Stall is combinational from the current Cnt values: Stall = (UsesRs1 & Rs1!=0 & Cnt[Rs1]!=0) | (UsesRs2 & Rs2!=0 & Cnt[Rs2]!=0).
- Every cycle, each nonzero Cnt decrements by 1 and saturates at 0.
- Issue: when IssueValid & IssueWrites & IssueRd!=0 & !Stall, Cnt[IssueRd] loads max(IssueLatency, Cnt[IssueRd]-1).
  - The max keeps a younger short-latency write from unmasking an older long-latency write (WAW).
  - Latency 0 therefore leaves the register not pending.
  - IssueLatency at the maximum value loads as-is; there is no overflow.
- Issue while Stall=1 is ignored; upstream must not assert IssueValid in that case, and the block guards against it regardless.
- Register 0: never marked pending and never causes a stall.
- Flush: at the edge, all Cnt are set to 0, overriding decrement and any same-cycle issue. Stall may still be high in the flush cycle itself; it is low the cycle after.
- Precedence per register at an edge: reset > flush > issue load > decrement.
- Busy is registered: it reflects whether any Cnt is nonzero after the edge's update.
- Latency from an issue with IssueLatency=L to Stall deassertion for a dependent instruction: Stall is high for exactly L cycles after the issue edge.

Optional Feature:
- Macro: DEC_SCOREBOARD_STATS_EN.
- When defined, add output StallCycles [0:31]:
  - a counter incremented on every clock edge where Stall=1 and Flush=0;
  - saturates at 32'hFFFFFFFF;
  - cleared by rst_n only.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with Rs1=5, UsesRs1=1 -> Stall=0, Busy=0 after release.
- Load-use: issue Rd=7, Latency=1; next cycle Rs1=7, UsesRs1=1 -> Stall=1 for 1 cycle, then 0; Busy falls with it.
- Mult: issue Rd=9, Latency=4; Rs2=9 thereafter -> Stall high exactly 4 cycles; Rs1=10 in the same window -> no stall.
- WAW: issue Rd=3 Lat=6; next cycle issue Rd=3 Lat=1 -> Cnt[3]=5, not 1; a dependent instruction stalls 5 more cycles.
- Register 0 and Flush: issue Rd=0 Lat=5 -> no stall on Rs1=0. Issue Rd=4 Lat=5, then Flush together with an issue Rd=4 Lat=3 -> Rs1=4 sees Stall=0 the next cycle, Busy=0.
- Stats (macro defined): 4-cycle stall scenario -> StallCycles=4; a further 2 stalls with Flush high in one of them -> StallCycles=5.
